clock_set_ctrl: RTL

//  User time-set controller for the 12-hour clock. Sequences debounced button pulses through

---
 rtl/clock_pkg.sv | 30 +++
 rtl/time_field_stepper.sv | 24 ++
 rtl/clock_set_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the 12-hour clock: state encodings, edit field codes and field ranges.
package clock_pkg;

    localparam int HOUR_W   = 4;
    localparam int MIN_W    = 6;
    localparam int HOUR_MIN = 1;
    localparam int HOUR_MAX = 12;
    localparam int MIN_MAX  = 59;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EDIT_HOUR = 3'd1;
    localparam logic [2:0] ST_EDIT_MIN  = 3'd2;
    localparam logic [2:0] ST_EDIT_AMPM = 3'd3;
    localparam logic [2:0] ST_COMMIT    = 3'd4;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_AMPM = 2'd3;

    function automatic logic [1:0] field_of(input logic [2:0] st);
        case (st)
            ST_EDIT_HOUR: return FIELD_HOUR;
            ST_EDIT_MIN:  return FIELD_MIN;
            ST_EDIT_AMPM: return FIELD_AMPM;
            default:      return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_field_stepper.sv
// Combinational wrap-around +/-1 of one time field within LO..HI; up and down together hold.
module time_field_stepper #(
    parameter int LO = 0,
    parameter int HI = 59,
    parameter int W  = 6
) (
    input  logic [W-1:0] value,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] result
);

    localparam logic [W-1:0] LO_V = W'(LO);
    localparam logic [W-1:0] HI_V = W'(HI);

    always_comb begin
        result = value;
        if (up && !down)
            result = (value == HI_V) ? LO_V : value + W'(1);
        else if (down && !up)
            result = (value == LO_V) ? HI_V : value - W'(1);
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: edits a frozen shadow of the live time field by field and strobes it
// into the clock on commit.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_cancel,
    input  logic              cur_isPM,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              propagate,
    output logic              in_PM,
    output logic [HOUR_W-1:0] in_hours,
    output logic [MIN_W-1:0]  in_minutes,
    output logic              editing,
    output logic [1:0]        edit_field
);

    logic [2:0]        state, next_state;
    logic [31:0]       tcount;
    logic [HOUR_W-1:0] hour_next;
    logic [MIN_W-1:0]  min_next;
    logic              any_btn, in_edit, next_in_edit;
    logic              step_up, step_down;

    assign any_btn   = btn_mode | btn_up | btn_down | btn_cancel;
    // cancel and mode outrank an edit in the same cycle
    assign step_up   = btn_up   & ~btn_down & ~btn_mode & ~btn_cancel;
    assign step_down = btn_down & ~btn_up   & ~btn_mode & ~btn_cancel;
    assign in_edit      = (field_of(state) != FIELD_NONE);
    assign next_in_edit = (field_of(next_state) != FIELD_NONE);

    time_field_stepper #(.LO(HOUR_MIN), .HI(HOUR_MAX), .W(HOUR_W)) u_hour_step (
        .value  (in_hours),
        .up     (step_up),
        .down   (step_down),
        .result (hour_next)
    );

    time_field_stepper #(.LO(0), .HI(MIN_MAX), .W(MIN_W)) u_min_step (
        .value  (in_minutes),
        .up     (step_up),
        .down   (step_down),
        .result (min_next)
    );

    // NOTE: next_state is assigned a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (btn_mode) next_state = ST_EDIT_HOUR;
            ST_EDIT_HOUR,
            ST_EDIT_MIN,
            ST_EDIT_AMPM: begin
                if (btn_cancel)
                    next_state = ST_IDLE;
                else if (btn_mode)
                    next_state = (state == ST_EDIT_HOUR) ? ST_EDIT_MIN :
                                 (state == ST_EDIT_MIN)  ? ST_EDIT_AMPM : ST_COMMIT;
                else if (!any_btn && tcount == TIMEOUT_CYCLES - 32'd1)
                    next_state = ST_IDLE;
            end
            default:      next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tcount     <= '0;
            propagate  <= 1'b0;
            editing    <= 1'b0;
            edit_field <= FIELD_NONE;
            in_PM      <= 1'b0;
            in_hours   <= HOUR_W'(HOUR_MAX);
            in_minutes <= '0;
        end else begin
            state      <= next_state;
            propagate  <= (next_state == ST_COMMIT);
            editing    <= next_in_edit;
            edit_field <= field_of(next_state);

            // Counting runs only while staying in edit without button activity
            if (in_edit && next_in_edit && !any_btn)
                tcount <= tcount + 32'd1;
            else
                tcount <= '0;

            if (state == ST_IDLE && btn_mode) begin
                in_PM      <= cur_isPM;
                in_minutes <= cur_minutes;
                in_hours   <= (cur_hours >= HOUR_W'(HOUR_MIN) && cur_hours <= HOUR_W'(HOUR_MAX))
                              ? cur_hours : HOUR_W'(HOUR_MAX);
            end else if (state == ST_EDIT_HOUR) begin
                in_hours <= hour_next;
            end else if (state == ST_EDIT_MIN) begin
                in_minutes <= min_next;
            end else if (state == ST_EDIT_AMPM && (step_up || step_down)) begin
                in_PM <= ~in_PM;
            end
        end
    end

endmodule
